pdm_envelope_ctrl: RTL

Time-multiplexed attack/decay/sustain/release envelope controller for up to 24 synth voices. It feeds the shared PDM output stage. Once per envelope tick it sweeps every voice, one voice per clock, and advances each voice's envelope state and 8-bit level. It sums the levels into one amplitude word and presents that word with a per-voice activity mask to the PDM modulator's `dc_in` and `gate_in`.

---
 rtl/pdm_envelope_ctrl_if.sv | 28 ++
 rtl/pdm_envelope_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pdm_envelope_ctrl_if.sv
// Bus between the envelope controller and its surroundings: per-voice gates,
// the ADSR step/level settings, and the mixed amplitude / activity mask that
// feed the shared PDM output stage.
interface pdm_envelope_ctrl_if #(
  parameter int NUM_VOICES = 24,
  parameter int DC_WIDTH   = 8
);
  logic [NUM_VOICES-1:0] gate_in;
  logic [DC_WIDTH-1:0]   attack_step_in;
  logic [DC_WIDTH-1:0]   decay_step_in;
  logic [DC_WIDTH-1:0]   sustain_level_in;
  logic [DC_WIDTH-1:0]   release_step_in;
  logic [DC_WIDTH-1:0]   dc_out;
  logic [23:0]           gate_out;
  logic                  sweep_done_out;

  // Side that supplies gates/settings and consumes the mix.
  modport master (
    output gate_in, attack_step_in, decay_step_in, sustain_level_in, release_step_in,
    input  dc_out, gate_out, sweep_done_out
  );

  // Envelope controller side.
  modport slave (
    input  gate_in, attack_step_in, decay_step_in, sustain_level_in, release_step_in,
    output dc_out, gate_out, sweep_done_out
  );
endinterface

// File: rtl/pdm_envelope_ctrl.sv
// Time-multiplexed ADSR envelope controller. Once per envelope tick it walks
// every voice (one per clock), advances its state and level, sums the levels
// and publishes the mix plus an activity mask for the PDM modulator.
// Optional build macro PDM_ENV_AVG_EN: averaged mix (sum >> clog2(NUM_VOICES))
// instead of the default saturating mix min(sum, full scale).
module pdm_envelope_ctrl #(
  parameter int NUM_VOICES = 24,
  parameter int DC_WIDTH   = 8,
  parameter int TICK_DIV   = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  pdm_envelope_ctrl_if.slave    env
);

  localparam int ACC_W = DC_WIDTH + 5;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [DC_WIDTH-1:0] FS       = '1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TICK_DIV - 1);
`ifdef PDM_ENV_AVG_EN
  localparam int AVG_SH = $clog2(NUM_VOICES);
`endif

  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_DONE} sw_state_t;
  typedef enum logic [2:0] {V_IDLE, V_ATTACK, V_DECAY, V_SUSTAIN, V_RELEASE} vstate_t;

  // Mix rule: averaged or saturated to full scale.
  function automatic logic [DC_WIDTH-1:0] mix(input logic [ACC_W-1:0] s);
`ifdef PDM_ENV_AVG_EN
    return DC_WIDTH'(s >> AVG_SH);
`else
    return (s > ACC_W'(FS)) ? FS : s[DC_WIDTH-1:0];
`endif
  endfunction

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  sw_state_t             sw_state, sw_next;
  logic [IDX_W-1:0]      idx;
  logic                  run, last;

  logic [NUM_VOICES-1:0] gate_p0;
  logic [DC_WIDTH-1:0]   attack_p0, decay_p0, sustain_p0, release_p0;

  vstate_t               v_state [NUM_VOICES];
  logic [DC_WIDTH-1:0]   v_level [NUM_VOICES];

  vstate_t               cur_st, nxt_st;
  logic [DC_WIDTH-1:0]   cur_lv, nxt_lv;
  logic                  g;
  logic [DC_WIDTH:0]     sum_att, sus_dec;

  logic [ACC_W-1:0]      acc_p1, acc_next;
  logic [23:0]           gate_p1, gate_next;
  logic [DC_WIDTH-1:0]   dc_p2;
  logic [23:0]           gate_p2;
  logic                  vld_p2;

  assign tick = (cnt == CNT_MAX);

  // Free-running envelope tick counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)     cnt <= '0;
    else if (tick)  cnt <= '0;
    else            cnt <= cnt + 1'b1;
  end

  // Sweep FSM state and voice index.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sw_state <= SW_IDLE;
      idx      <= '0;
    end else begin
      sw_state <= sw_next;
      idx      <= run ? idx + 1'b1 : '0;
    end
  end

  // Sweep FSM next state: start on tick, walk all voices, one publish cycle.
  always_comb begin
    sw_next = sw_state;
    run     = (sw_state == SW_RUN);
    last    = run && (idx == LAST_IDX);
    case (sw_state)
      SW_IDLE: if (tick) sw_next = SW_RUN;
      SW_RUN:  if (last) sw_next = SW_DONE;
      SW_DONE: sw_next = SW_IDLE;
      default: sw_next = SW_IDLE;
    endcase
  end

  // ---- p0: settings snapshot taken on the tick ----
  // Capture gates and step/level settings once per tick.
  always_ff @(posedge clk_in) begin
    if (tick) begin
      gate_p0    <= env.gate_in;
      attack_p0  <= env.attack_step_in;
      decay_p0   <= env.decay_step_in;
      sustain_p0 <= env.sustain_level_in;
      release_p0 <= env.release_step_in;
    end
  end

  // ---- p1: per-voice envelope update at index idx ----
  // Next state/level for the voice currently addressed by the sweep.
  always_comb begin
    cur_st  = v_state[idx];
    cur_lv  = v_level[idx];
    g       = gate_p0[idx];
    nxt_st  = cur_st;
    nxt_lv  = cur_lv;
    sum_att = {1'b0, cur_lv} + {1'b0, attack_p0};
    sus_dec = {1'b0, sustain_p0} + {1'b0, decay_p0};
    case (cur_st)
      V_IDLE: if (g) nxt_st = V_ATTACK;
      V_ATTACK:
        if (!g) nxt_st = V_RELEASE;
        else if (sum_att >= {1'b0, FS} || attack_p0 == '0) begin
          nxt_lv = FS;
          nxt_st = V_DECAY;
        end else nxt_lv = sum_att[DC_WIDTH-1:0];
      V_DECAY:
        if (!g) nxt_st = V_RELEASE;
        else if ({1'b0, cur_lv} <= sus_dec || decay_p0 == '0) begin
          nxt_lv = sustain_p0;
          nxt_st = V_SUSTAIN;
        end else nxt_lv = cur_lv - decay_p0;
      V_SUSTAIN:
        if (!g) nxt_st = V_RELEASE;
        else    nxt_lv = sustain_p0;
      V_RELEASE:
        if (g) nxt_st = V_ATTACK;
        else if (cur_lv <= release_p0 || release_p0 == '0) begin
          nxt_lv = '0;
          nxt_st = V_IDLE;
        end else nxt_lv = cur_lv - release_p0;
      default: begin
        nxt_st = V_IDLE;
        nxt_lv = '0;
      end
    endcase
    acc_next  = acc_p1 + ACC_W'(nxt_lv);
    gate_next = gate_p1 | ((nxt_st != V_IDLE) ? (24'(1) << idx) : 24'(0));
  end

  // Write back the updated voice.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        v_state[k] <= V_IDLE;
        v_level[k] <= '0;
      end
    end else if (run) begin
      v_state[idx] <= nxt_st;
      v_level[idx] <= nxt_lv;
    end
  end

  // Running level sum and activity mask, cleared on the tick.
  always_ff @(posedge clk_in) begin
    if (tick) begin
      acc_p1  <= '0;
      gate_p1 <= '0;
    end else if (run) begin
      acc_p1  <= acc_next;
      gate_p1 <= gate_next;
    end
  end

  // ---- p2: publish mix and mask after the last voice ----
  // Outputs hold until the next sweep completes; done pulses for one cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dc_p2   <= '0;
      gate_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= last;
      if (last) begin
        dc_p2   <= mix(acc_next);
        gate_p2 <= gate_next;
      end
    end
  end

  assign env.dc_out         = dc_p2;
  assign env.gate_out       = gate_p2;
  assign env.sweep_done_out = vld_p2;

endmodule
